led_arb: RTL and testbench
==========================

LED_ARB -- requirements
Module: led_arb

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, SHALL set the minimum ownership time in clk cycles before non-error preemption.
REQ-002 Parameter BLINK_DIV, default 25000000, SHALL set clk cycles per blink half-period.
REQ-003 clk  in  1  SHALL be the single clock; all state is updated on posedge clk.
REQ-004 rst_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 stb  in  1  SHALL be the IO strobe; we  in  1  SHALL select write (1) or read (0).
REQ-006 data_in  in  32  SHALL carry the CPU control word: [7:0] CPU pattern, [8] CPU request, [9] CPU lock.
REQ-007 data_out  out  32  SHALL return the status word on read and 0 otherwise.
REQ-008 ack  out  1  SHALL equal stb combinationally.
REQ-009 req_in  in  2  SHALL carry the requests of requester 1 (bit 0) and requester 2 (bit 1, error).
REQ-010 pat1_in, pat2_in  in  8 each  SHALL carry the LED patterns of requesters 1 and 2.
REQ-011 leds  out  8  SHALL drive the shared LEDs, registered.
REQ-012 gnt  out  3  SHALL be the registered one-hot grant; bit 0 = CPU, bit 1 = req 1, bit 2 = req 2.

Function
REQ-013 A write (stb & we) SHALL load ctrl[9:0] from data_in[9:0]; the new value SHALL be used for arbitration from the following cycle.
REQ-014 A read (stb & ~we) SHALL return {7'b0, blink_phase, 5'b0, gnt[2:0], 6'b0, ctrl[9:0]}.
REQ-015 Priority SHALL be fixed: requester 2 > 1 > 0 (CPU), with the CPU request being ctrl[8].
REQ-016 The FSM SHALL have the states IDLE, GRANT and LOCK.
REQ-017 In IDLE, leds and gnt SHALL be 0; on any active request, the FSM SHALL grant the highest-priority requester, enter GRANT and load the hold counter with HOLD_CYCLES-1.
REQ-018 In GRANT, the hold counter SHALL decrement once per cycle and saturate at 0.
REQ-019 In GRANT, a higher-priority request SHALL preempt the owner only when the counter is 0; requester 2 SHALL preempt immediately.
REQ-020 On preemption, the counter SHALL be reloaded with HOLD_CYCLES-1.
REQ-021 If the owner drops its request, the FSM SHALL re-arbitrate in the same cycle (counter reloaded), or go to IDLE when no request is active.
REQ-022 When ctrl[9] is set and req_in[1] is 0, the FSM SHALL enter LOCK with the CPU as owner, regardless of ctrl[8] and the hold counter.
REQ-023 LOCK SHALL exit to re-arbitration when ctrl[9] clears; requester 2 SHALL preempt LOCK and return to LOCK after req_in[1] drops if ctrl[9] is still set.
REQ-024 leds SHALL equal the owner's pattern one cycle after the grant decision; for owner 2, leds SHALL be 0 while blink_phase = 0.
REQ-025 The blink counter SHALL free-run from 0 to BLINK_DIV-1, wrap to 0 and toggle blink_phase on wrap.
REQ-026 gnt SHALL always be one-hot or zero; zero only in IDLE.

Reset
REQ-027 While rst_n = 0: ctrl, leds, gnt, hold counter and blink counter = 0, blink_phase = 1, FSM = IDLE.
REQ-028 Assertion of reset mid-grant SHALL clear outputs without waiting for clk; arbitration SHALL resume on the first clk edge after deassertion.

Structure
REQ-029 Package lsb_pkg SHALL hold the FSM state encoding, requester indices (CPU=0, R1=1, ERR=2) and the ctrl bit positions.
REQ-030 The blink divider SHALL be a sub-module blink_tmr (clk, rst_n, phase output), parameterised by BLINK_DIV.

Verification (HOLD_CYCLES=4, BLINK_DIV=8)
REQ-031 Write 0x1A5, then raise no other request -> next cycle gnt=001; following cycle leds=0xA5.
REQ-032 CPU owns; req_in[0]=1 with pat1=0x0F one cycle later -> gnt stays 001 for 4 cycles of ownership, then becomes 010 and leds=0x0F.
REQ-033 Requester 1 owns; req_in[1]=1 with pat2=0xFF -> gnt=100 on the next edge, leds alternate 0xFF/0x00 every 8 cycles.
REQ-034 Write 0x2C3 (lock) while req 1 is active -> gnt=001 and leds=0xC3 regardless of the hold counter; pulse req_in[1] -> 100 then back to 001; write 0x000 -> gnt=010.
REQ-035 rst_n low mid-grant -> leds=0 and gnt=0 immediately; a read after release returns 0x01000000.

Source files
------------

// File: rtl/lsb_pkg.sv
// Shared definitions for the LED arbiter: FSM encoding, requester indices,
// control-word bit positions and the fixed-priority pick helper.
package lsb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  localparam int unsigned N_REQ   = 3;
  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_R1  = 1;
  localparam int unsigned REQ_ERR = 2;

  localparam int unsigned CTRL_W    = 10;
  localparam int unsigned CTRL_REQ  = 8;
  localparam int unsigned CTRL_LOCK = 9;

  localparam logic [N_REQ-1:0] GNT_CPU = 3'b001;
  localparam logic [N_REQ-1:0] GNT_R1  = 3'b010;
  localparam logic [N_REQ-1:0] GNT_ERR = 3'b100;

  // One-hot of the highest-priority active request (ERR > R1 > CPU), or zero.
  function automatic logic [N_REQ-1:0] pick_highest(input logic [N_REQ-1:0] req);
    logic [N_REQ-1:0] g;
    g = '0;
    if (req[REQ_ERR])     g = GNT_ERR;
    else if (req[REQ_R1]) g = GNT_R1;
    else if (req[REQ_CPU]) g = GNT_CPU;
    return g;
  endfunction

endpackage

// File: rtl/blink_tmr.sv
// Free-running blink divider: counts 0..BLINK_DIV-1 and toggles phase on wrap.
module blink_tmr
  #(parameter int unsigned BLINK_DIV = 25000000)
  (
    input  logic clk,
    input  logic rst_n,
    output logic phase
  );

  localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_arb.sv
// Shared-LED arbiter between CPU, requester 1 and error requester 2, with
// minimum hold time, CPU lock mode and blinking display for the error owner.
module led_arb
  import lsb_pkg::*;
  #(
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned BLINK_DIV   = 25000000
  )
  (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic [1:0]  req_in,
    input  logic [7:0]  pat1_in,
    input  logic [7:0]  pat2_in,
    output logic [7:0]  leds,
    output logic [2:0]  gnt
  );

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t              state;
  logic [CTRL_W-1:0]   ctrl;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                blink_phase;

  logic [N_REQ-1:0]    req_vec;
  logic [N_REQ-1:0]    best;
  logic                any_req;
  logic                lock_req;
  logic                owner_active;
  logic                err_preempt;
  logic                hold_preempt;
  logic                unused_data;

  blink_tmr #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .phase (blink_phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ctrl <= '0;
    else if (stb && we)  ctrl <= data_in[CTRL_W-1:0];
  end

  always_comb begin
    ack         = stb;
    unused_data = ^data_in[31:CTRL_W];
    data_out    = '0;
    if (stb && !we)
      data_out = {7'b0, blink_phase, 5'b0, gnt, 6'b0, ctrl};
  end

  always_comb begin
    req_vec      = {req_in[1], req_in[0], ctrl[CTRL_REQ]};
    best         = pick_highest(req_vec);
    any_req      = |req_vec;
    lock_req     = ctrl[CTRL_LOCK] & ~req_in[1];
    owner_active = |(gnt & req_vec);
    err_preempt  = req_vec[REQ_ERR] & ~gnt[REQ_ERR];
    // With the owner still requesting, best differs only if it outranks the owner.
    hold_preempt = (best != gnt) && (hold_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lock_req) begin
            state    <= ST_LOCK;
            gnt      <= GNT_CPU;
            hold_cnt <= HOLD_RELOAD;
          end else if (any_req) begin
            state    <= ST_GRANT;
            gnt      <= best;
            hold_cnt <= HOLD_RELOAD;
          end else begin
            gnt      <= '0;
          end
        end

        ST_GRANT: begin
          if (lock_req) begin
            state    <= ST_LOCK;
            gnt      <= GNT_CPU;
            hold_cnt <= HOLD_RELOAD;
          end else if (!owner_active) begin
            if (any_req) begin
              gnt      <= best;
              hold_cnt <= HOLD_RELOAD;
            end else begin
              state    <= ST_IDLE;
              gnt      <= '0;
              hold_cnt <= '0;
            end
          end else if (err_preempt || hold_preempt) begin
            gnt      <= best;
            hold_cnt <= HOLD_RELOAD;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        ST_LOCK: begin
          if (req_vec[REQ_ERR]) begin
            state    <= ST_GRANT;
            gnt      <= GNT_ERR;
            hold_cnt <= HOLD_RELOAD;
          end else if (!ctrl[CTRL_LOCK]) begin
            if (any_req) begin
              state    <= ST_GRANT;
              gnt      <= best;
              hold_cnt <= HOLD_RELOAD;
            end else begin
              state    <= ST_IDLE;
              gnt      <= '0;
              hold_cnt <= '0;
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          gnt      <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Display follows the registered owner, so it lags the grant by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= '0;
    end else begin
      case (gnt)
        GNT_CPU: leds <= ctrl[7:0];
        GNT_R1:  leds <= pat1_in;
        GNT_ERR: leds <= blink_phase ? pat2_in : 8'h00;
        default: leds <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_arb.sv
// Self-checking bench for led_arb: directed scenarios followed by random
// traffic, all checked against a behavioural owner/age model.
module tb_led_arb;

  localparam int unsigned HOLD = 4;
  localparam int unsigned DIV  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb;
  logic        we;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic [1:0]  req_in;
  logic [7:0]  pat1_in;
  logic [7:0]  pat2_in;
  logic [7:0]  leds;
  logic [2:0]  gnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: who owns the LEDs, whether the CPU lock holds them,
  // and how many edges the current owner has kept them.
  int          m_owner;
  bit          m_locked;
  int          m_age;
  logic [9:0]  m_ctrl;
  int unsigned m_edges;
  logic [7:0]  m_leds;

  logic [1:0]  cur_req;
  logic [7:0]  cur_p1;
  logic [7:0]  cur_p2;

  always #5 clk = ~clk;

  led_arb #(.HOLD_CYCLES(HOLD), .BLINK_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stb      (stb),
    .we       (we),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .req_in   (req_in),
    .pat1_in  (pat1_in),
    .pat2_in  (pat2_in),
    .leds     (leds),
    .gnt      (gnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic m_phase();
    return ((m_edges / DIV) % 2) == 0;
  endfunction

  function automatic logic [2:0] m_gnt();
    if (m_owner < 0) return 3'b000;
    return 3'(1 << m_owner);
  endfunction

  function automatic logic [31:0] m_status();
    return {7'b0, m_phase(), 5'b0, m_gnt(), 6'b0, m_ctrl};
  endfunction

  function automatic int top_req(input logic [2:0] r);
    if (r[2]) return 2;
    if (r[1]) return 1;
    if (r[0]) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_locked = 0;
    m_age    = 0;
    m_ctrl   = '0;
    m_edges  = 0;
    m_leds   = '0;
  endtask

  task automatic model_edge();
    logic [2:0] r;
    logic [7:0] nl;
    int best;
    case (m_owner)
      0:       nl = m_ctrl[7:0];
      1:       nl = pat1_in;
      2:       nl = m_phase() ? pat2_in : 8'h00;
      default: nl = 8'h00;
    endcase
    r    = {req_in[1], req_in[0], m_ctrl[8]};
    best = top_req(r);
    if (m_ctrl[9] && !req_in[1]) begin
      if (!m_locked) begin
        m_owner  = 0;
        m_locked = 1;
      end
    end else if (m_locked || m_owner < 0 || !r[m_owner]) begin
      m_owner  = best;
      m_locked = 0;
      m_age    = 0;
    end else if (best != m_owner && (best == 2 || m_age >= int'(HOLD) - 1)) begin
      m_owner = best;
      m_age   = 0;
    end else begin
      m_age++;
    end
    m_leds = nl;
    if (stb && we) m_ctrl = data_in[9:0];
    m_edges++;
  endtask

  task automatic cycle(input logic s, input logic w, input logic [31:0] d);
    stb     = s;
    we      = w;
    data_in = d;
    req_in  = cur_req;
    pat1_in = cur_p1;
    pat2_in = cur_p2;
    #1;
    chk("ack", 32'(ack), 32'(s));
    chk("data_out", data_out, (s && !w) ? m_status() : 32'h0);
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt", 32'(gnt), 32'(m_gnt()));
    chk("leds", 32'(leds), 32'(m_leds));
  endtask

  task automatic tick();
    cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] d);
    cycle(1'b1, 1'b1, d);
  endtask

  initial begin
    int own;
    logic [31:0] d;
    int unsigned op;

    rst_n = 1'b0; stb = 1'b0; we = 1'b0; data_in = '0;
    req_in = '0; pat1_in = '0; pat2_in = '0;
    cur_req = '0; cur_p1 = '0; cur_p2 = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    stb = 1'b1; we = 1'b0;
    #1;
    chk("rst_status", data_out, 32'h0100_0000);
    stb = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // CPU request with pattern A5, no other requester
    wr(32'hDEAD_01A5);
    tick();
    chk("r031_gnt", 32'(gnt), 32'h1);
    tick();
    chk("r031_leds", 32'(leds), 32'hA5);

    // Requester 1 waits out the CPU hold time
    cur_req = 2'b01; cur_p1 = 8'h0F;
    own = 2;
    for (int i = 0; i < 12 && gnt == 3'b001; i++) begin
      tick();
      if (gnt == 3'b001) own++;
    end
    chk("r032_own_cycles", 32'(own), 32'd4);
    chk("r032_gnt", 32'(gnt), 32'h2);
    tick();
    chk("r032_leds", 32'(leds), 32'h0F);

    // Error requester preempts at once and blinks
    cur_req = 2'b11; cur_p2 = 8'hFF;
    tick();
    chk("r033_gnt", 32'(gnt), 32'h4);
    repeat (20) tick();
    cur_req = 2'b01;
    tick();
    chk("r033_back_r1", 32'(gnt), 32'h2);

    // CPU lock overrides requester 1; error requester interrupts the lock
    wr(32'h0000_02C3);
    tick();
    chk("r034_lock_gnt", 32'(gnt), 32'h1);
    tick();
    chk("r034_lock_leds", 32'(leds), 32'hC3);
    cur_req = 2'b11;
    tick();
    chk("r034_err_gnt", 32'(gnt), 32'h4);
    cur_req = 2'b01;
    tick();
    chk("r034_relock_gnt", 32'(gnt), 32'h1);
    wr(32'h0);
    tick();
    chk("r034_unlock_gnt", 32'(gnt), 32'h2);
    repeat (3) tick();

    // Asynchronous reset in the middle of a grant
    #3 rst_n = 1'b0;
    #1;
    chk("r035_gnt", 32'(gnt), 32'h0);
    chk("r035_leds", 32'(leds), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    stb = 1'b1; we = 1'b0;
    #1;
    chk("r035_read", data_out, 32'h0100_0000);
    cycle(1'b1, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) begin
        cur_req[0] = 1'($urandom_range(1));
        cur_req[1] = ($urandom_range(3) == 0);
      end
      cur_p1 = 8'($urandom);
      cur_p2 = 8'($urandom);
      op = $urandom_range(9);
      d  = $urandom;
      if (op == 0) begin
        d[9] = ($urandom_range(3) == 0);
        cycle(1'b1, 1'b1, d);
      end else if (op < 3) begin
        cycle(1'b1, 1'b0, d);
      end else begin
        cycle(1'b0, 1'($urandom_range(1)), d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
